sprite_blitter: RTL

Draws rectangular sprites from a sprite ROM into the hidden frame of the double-buffered SRAM frame buffer. It accepts one draw command at a time over a valid/ready handshake and walks the sprite pixel by pixel. Opaque, on-screen pixels are presented on the program write port (`program_x/y/data/write`) of the SRAM controller, each held long enough to land in one SRAM write slot. It sits directly upstream of the SRAM controller, between the game logic's draw list and the frame buffer.

---
 rtl/blitter_pkg.sv | 15 +
 rtl/frame_edge_detect.sv | 27 ++
 rtl/sprite_blitter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/blitter_pkg.sv
// Shared types and constants for the frame-buffer drawing blocks.
package blitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        EMIT  = 2'd3
    } blit_state_e;

    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned SCREEN_H        = 480;
    localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector for the frame toggle: one sampling flop, one history flop, registered pulse.
module frame_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sample_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sample_q <= sig_i;
            prev_q   <= sample_q;
            rise_q   <= sample_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite ROM and presents opaque pixels on the SRAM program port.
// Optional macro BLIT_CLIP_EN skips pixels that fall outside the 640x480 screen.
module sprite_blitter
    import blitter_pkg::*;
#(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          SPRITE_ID_W = 4,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY
) (
    input  logic                                                     sram_clk,
    input  logic                                                     reset,
    input  logic                                                     frame_clk,
    input  logic                                                     cmd_valid,
    output logic                                                     cmd_ready,
    input  logic [9:0]                                               cmd_x,
    input  logic [9:0]                                               cmd_y,
    input  logic [SPRITE_ID_W-1:0]                                   cmd_id,
    output logic [SPRITE_ID_W+$clog2(SPRITE_W)+$clog2(SPRITE_H)-1:0] rom_addr,
    input  logic [15:0]                                              rom_data,
    output logic [9:0]                                               program_x,
    output logic [9:0]                                               program_y,
    output logic [15:0]                                              program_data,
    output logic                                                     program_write,
    output logic                                                     busy,
    output logic                                                     overrun
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);

    blit_state_e      state_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [SPRITE_ID_W-1:0] id_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SPRITE_ID_W+ROW_W+COL_W-1:0] rom_addr_q;
    logic [9:0]       px_q;
    logic [9:0]       py_q;
    logic [15:0]      pdata_q;
    logic             pwrite_q;
    logic             overrun_q;

    logic             frame_edge;
    logic [10:0]      sum_x;
    logic [10:0]      sum_y;
    logic             on_screen;
    logic             writable;
    logic             last_pix;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;

    frame_edge_detect u_edge (
        .clk_i   (sram_clk),
        .reset_i (reset),
        .sig_i   (frame_clk),
        .rise_o  (frame_edge)
    );

    // Eleven-bit sums keep the carry visible to the clip test.
    assign sum_x = {1'b0, x_q} + 11'(col_q);
    assign sum_y = {1'b0, y_q} + 11'(row_q);

`ifdef BLIT_CLIP_EN
    assign on_screen = (sum_x < 11'(SCREEN_W)) && (sum_y < 11'(SCREEN_H));
`else
    logic unused_carry;
    assign unused_carry = sum_x[10] ^ sum_y[10];
    assign on_screen    = 1'b1;
`endif

    assign writable = (rom_data != TRANSPARENT) && on_screen;
    assign last_pix = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign col_nxt  = col_q + COL_W'(1);
    assign row_nxt  = (col_q == COL_MAX) ? row_q + ROW_W'(1) : row_q;

    // Command handshake: a command transfers on a rising sram_clk edge where
    // cmd_valid && cmd_ready; cmd_ready never depends on cmd_valid.
    assign cmd_ready = (state_q == IDLE) && !frame_edge;

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pdata_q    <= '0;
            pwrite_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_edge && state_q != IDLE) begin
                state_q   <= IDLE;
                pwrite_q  <= 1'b0;
                overrun_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            x_q        <= cmd_x;
                            y_q        <= cmd_y;
                            id_q       <= cmd_id;
                            row_q      <= '0;
                            col_q      <= '0;
                            rom_addr_q <= {cmd_id, ROW_W'(0), COL_W'(0)};
                            state_q    <= FETCH;
                        end
                    end
                    FETCH: state_q <= DATA;
                    DATA: begin
                        if (writable) begin
                            px_q     <= sum_x[9:0];
                            py_q     <= sum_y[9:0];
                            pdata_q  <= rom_data;
                            pwrite_q <= 1'b1;
                            cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
                            state_q  <= EMIT;
                        end else begin
                            col_q      <= col_nxt;
                            row_q      <= row_nxt;
                            rom_addr_q <= {id_q, row_nxt, col_nxt};
                            state_q    <= last_pix ? IDLE : FETCH;
                        end
                    end
                    EMIT: begin
                        if (cnt_q == '0) begin
                            pwrite_q   <= 1'b0;
                            col_q      <= col_nxt;
                            row_q      <= row_nxt;
                            rom_addr_q <= {id_q, row_nxt, col_nxt};
                            state_q    <= last_pix ? IDLE : FETCH;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign rom_addr      = rom_addr_q;
    assign program_x     = px_q;
    assign program_y     = py_q;
    assign program_data  = pdata_q;
    assign program_write = pwrite_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule
